// File: rtl/dcache_pkg.sv
// Shared types and helpers for the set-associative write-back data cache.
// Widths derive from the cache geometry parameters of the top.
package dcache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB_REQ,
    RF_REQ,
    RF_WAIT,
    FILL
  } state_t;

  function automatic int off_w(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int line_bytes,
                               input int sets);
    return addr_w - $clog2(line_bytes) - $clog2(sets);
  endfunction

  function automatic int words_per_line(input int line_bytes,
                                        input int data_w);
    return (line_bytes * 8) / data_w;
  endfunction

  localparam int OFF_W          = off_w(64);
  localparam int IDX_W          = idx_w(256);
  localparam int TAG_W          = tag_w(32, 64, 256);
  localparam int WORDS_PER_LINE = words_per_line(64, 32);

  // Byte-enable merge on a word of up to 64 bits.
  function automatic logic [63:0] merge_word(input logic [63:0] old,
                                             input logic [63:0] wd,
                                             input logic [7:0]  strb);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++)
      if (strb[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/dcache_way_array.sv
// One cache way: tag/data storage plus valid/dirty bits, registered read.
// A same-index write in the read cycle is forwarded to the read outputs.
module dcache_way_array import dcache_pkg::*; #(
  parameter int IDX_W  = 8,
  parameter int TAG_W  = 18,
  parameter int LINE_W = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_data,
  input  logic              wr_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_dirty
);

  localparam int SETS = 1 << IDX_W;

  logic [TAG_W-1:0]  tags [SETS];
  logic [LINE_W-1:0] data [SETS];
  logic [SETS-1:0]   valid;
  logic [SETS-1:0]   dirty;
  logic              byp;

  assign byp = we && (wr_idx == rd_idx);

  always_ff @(posedge clk) begin
    if (we) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_data;
    end
    if (rd_en) begin
      rd_tag  <= byp ? wr_tag  : tags[rd_idx];
      rd_data <= byp ? wr_data : data[rd_idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid    <= '0;
      dirty    <= '0;
      rd_valid <= 1'b0;
      rd_dirty <= 1'b0;
    end else begin
      if (we) begin
        valid[wr_idx] <= 1'b1;
        dirty[wr_idx] <= wr_dirty;
      end
      if (rd_en) begin
        rd_valid <= byp | valid[rd_idx];
        rd_dirty <= byp ? wr_dirty : dirty[rd_idx];
      end
    end
  end

endmodule

// File: rtl/dcache_sa_wb.sv
// N-way set-associative write-back, write-allocate data cache with
// round-robin replacement, pipeline stall and hit/miss statistics.
module dcache_sa_wb import dcache_pkg::*; #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_BYTES = 64,
  parameter int SETS       = 256,
  parameter int WAYS       = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    memRW,
  input  logic [ADDR_W-1:0]       i_addr,
  input  logic [DATA_W-1:0]       dataW,
  input  logic [DATA_W/8-1:0]     wstrb,
  output logic                    resp_valid,
  output logic [DATA_W-1:0]       o_data,
  output logic                    stall,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic                    mem_req_we,
  output logic [ADDR_W-1:0]       mem_req_addr,
  output logic [LINE_BYTES*8-1:0] mem_wdata,
  input  logic                    mem_resp_valid,
  input  logic [LINE_BYTES*8-1:0] mem_rdata,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count
);

  localparam int OW = off_w(LINE_BYTES);
  localparam int IW = idx_w(SETS);
  localparam int TW = tag_w(ADDR_W, LINE_BYTES, SETS);
  localparam int LW = LINE_BYTES * 8;
  localparam int SW = DATA_W / 8;
  localparam int BW = $clog2(SW);
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;

  state_t            state, nstate;
  logic [ADDR_W-1:0] req_addr;
  logic              req_we;
  logic [DATA_W-1:0] req_data;
  logic [SW-1:0]     req_strb;
  logic              replay;
  logic [WW-1:0]     vic, vic_sel, hit_way;
  logic [LW-1:0]     fill_line;
  logic [WW-1:0]     rr [SETS];

  logic [TW-1:0]     req_tag;
  logic [IW-1:0]     req_idx, rd_idx;
  logic [OW-BW-1:0]  woff;
  logic              hit, lookup_hit, accept, rd_en;
  logic              vic_dirty, wr_dirty;
  logic [LW-1:0]     hit_line, st_line, wr_data;
  logic [DATA_W-1:0] hit_word, merged;
  logic [TW-1:0]     w_tag  [WAYS];
  logic [LW-1:0]     w_data [WAYS];
  logic [WAYS-1:0]   w_valid, w_dirty, w_we;
  logic              unused_ok;

  assign req_tag = req_addr[ADDR_W-1 -: TW];
  assign req_idx = req_addr[OW +: IW];
  assign woff    = req_addr[BW +: OW-BW];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (w_valid[w] && w_tag[w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WW'(w);
      end
    end
  end

  assign lookup_hit = (state == LOOKUP) && hit;
  assign hit_line   = w_data[hit_way];
  assign hit_word   = hit_line[woff*DATA_W +: DATA_W];
  assign merged     = DATA_W'(merge_word(64'(hit_word), 64'(req_data),
                                         8'(req_strb)));

  always_comb begin
    st_line = hit_line;
    st_line[woff*DATA_W +: DATA_W] = merged;
  end

  assign vic_sel   = (state == LOOKUP) ? rr[req_idx] : vic;
  assign vic_dirty = w_valid[vic_sel] && w_dirty[vic_sel];

  assign req_ready  = (state == IDLE) || lookup_hit;
  assign accept     = req_valid && req_ready;
  assign stall      = req_valid && !req_ready;
  assign resp_valid = lookup_hit;
  assign o_data     = lookup_hit ? (req_we ? merged : hit_word) : '0;

  assign rd_en  = accept || (state == FILL);
  assign rd_idx = (state == FILL) ? req_idx : i_addr[OW +: IW];

  assign wr_data  = (state == FILL) ? fill_line : st_line;
  assign wr_dirty = (state == FILL) ? 1'b0
                  : (w_dirty[hit_way] | (|req_strb));

  assign mem_req_valid = (state == WB_REQ) || (state == RF_REQ);
  assign mem_req_we    = (state == WB_REQ);
  assign mem_req_addr  = (state == WB_REQ)
                       ? {w_tag[vic_sel], req_idx, {OW{1'b0}}}
                       : {req_tag, req_idx, {OW{1'b0}}};
  assign mem_wdata     = w_data[vic_sel];

  assign unused_ok = ^{i_addr[BW-1:0], req_addr[BW-1:0]};

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign w_we[w] = ((state == FILL) && vic == WW'(w))
                  || (lookup_hit && req_we && hit_way == WW'(w));
    dcache_way_array #(
      .IDX_W (IW),
      .TAG_W (TW),
      .LINE_W(LW)
    ) u_way (
      .clk     (clk),
      .rst     (rst),
      .rd_en   (rd_en),
      .rd_idx  (rd_idx),
      .we      (w_we[w]),
      .wr_idx  (req_idx),
      .wr_tag  (req_tag),
      .wr_data (wr_data),
      .wr_dirty(wr_dirty),
      .rd_tag  (w_tag[w]),
      .rd_data (w_data[w]),
      .rd_valid(w_valid[w]),
      .rd_dirty(w_dirty[w])
    );
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (req_valid) nstate = LOOKUP;
      LOOKUP:
        if (hit)            nstate = req_valid ? LOOKUP : IDLE;
        else if (vic_dirty) nstate = WB_REQ;
        else                nstate = RF_REQ;
      WB_REQ:  if (mem_req_ready) nstate = RF_REQ;
      RF_REQ:  if (mem_req_ready) nstate = RF_WAIT;
      RF_WAIT: if (mem_resp_valid) nstate = FILL;
      FILL:    nstate = LOOKUP;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      req_addr <= i_addr;
      req_we   <= memRW;
      req_data <= dataW;
      req_strb <= wstrb;
    end
    if (state == RF_WAIT && mem_resp_valid) fill_line <= mem_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      replay     <= 1'b0;
      vic        <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      for (int s = 0; s < SETS; s++) rr[s] <= '0;
    end else begin
      state <= nstate;
      if (state == LOOKUP) begin
        if (hit) begin
          replay <= 1'b0;
          if (!replay && hit_count != '1)
            hit_count <= hit_count + 32'd1;
        end else begin
          vic <= rr[req_idx];
          if (miss_count != '1)
            miss_count <= miss_count + 32'd1;
        end
      end
      // Replay after fill must hit without counting as a hit.
      if (state == FILL) begin
        replay      <= 1'b1;
        rr[req_idx] <= (WAYS == 1) ? '0 : WW'(vic + 1'b1);
      end
    end
  end

endmodule

// File: tb/tb_dcache_sa_wb.sv
// Bench for dcache_sa_wb: vector table, response scoreboard and a
// line-wide backing memory model with fixed read latency.
module tb_dcache_sa_wb;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic         memRW;
  logic [31:0]  i_addr;
  logic [31:0]  dataW;
  logic [3:0]   wstrb;
  logic         resp_valid;
  logic [31:0]  o_data;
  logic         stall;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic         mem_req_we;
  logic [31:0]  mem_req_addr;
  logic [511:0] mem_wdata;
  logic         mem_resp_valid;
  logic [511:0] mem_rdata;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  dcache_sa_wb dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .memRW         (memRW),
    .i_addr        (i_addr),
    .dataW         (dataW),
    .wstrb         (wstrb),
    .resp_valid    (resp_valid),
    .o_data        (o_data),
    .stall         (stall),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_we    (mem_req_we),
    .mem_req_addr  (mem_req_addr),
    .mem_wdata     (mem_wdata),
    .mem_resp_valid(mem_resp_valid),
    .mem_rdata     (mem_rdata),
    .hit_count     (hit_count),
    .miss_count    (miss_count)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    int          exp_lat;
    int          exp_nreq;
    int          exp_hits;
    int          exp_miss;
  } vec_t;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [511:0] wdata;
  } mreq_t;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_q [$];
  mreq_t       mlog [$];
  logic [31:0] mem_store [logic [31:0]];
  logic        hold = 1'b0;
  vec_t        tbl [11];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired, expected DUT event", name);
  endtask

  function automatic logic [511:0] line_of(input logic [31:0] a);
    logic [511:0] l;
    logic [31:0]  wa;
    for (int w = 0; w < 16; w++) begin
      wa = a + 32'(w * 4);
      l[w*32 +: 32] = mem_store.exists(wa) ? mem_store[wa]
                                           : (wa ^ 32'h5A5A0000);
    end
    return l;
  endfunction

  // Backing memory: reads answer two cycles after the read handshake.
  initial begin
    logic        rd_pending;
    logic [31:0] rd_addr;
    int          rd_delay;
    mreq_t       m;
    rd_pending = 1'b0;
    rd_addr = '0;
    rd_delay = 0;
    mem_req_ready = 1'b1;
    mem_resp_valid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst && mem_req_valid && mem_req_ready) begin
        m.we = mem_req_we;
        m.addr = mem_req_addr;
        m.wdata = mem_wdata;
        mlog.push_back(m);
        if (mem_req_we) begin
          for (int w = 0; w < 16; w++)
            mem_store[mem_req_addr + 32'(w * 4)] = mem_wdata[w*32 +: 32];
        end else begin
          rd_pending = 1'b1;
          rd_addr = mem_req_addr;
          rd_delay = 2;
        end
      end
      @(posedge clk);
      #1;
      mem_resp_valid = 1'b0;
      mem_req_ready = !hold;
      if (!rst) begin
        rd_pending = 1'b0;
      end else if (rd_pending) begin
        if (rd_delay == 0) begin
          mem_resp_valid = 1'b1;
          mem_rdata = line_of(rd_addr);
          rd_pending = 1'b0;
        end else begin
          rd_delay--;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && resp_valid === 1'b1) begin
        if (exp_q.size() == 0) fail_now("unexpected resp_valid");
        else check("resp o_data", o_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_req(input logic we, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb,
                        input logic [31:0] exp, output int lat);
    bit acc;
    acc = 1'b0;
    lat = -1;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    memRW = we;
    i_addr = addr;
    dataW = data;
    wstrb = strb;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (!acc) begin
      fail_now("request accept");
      return;
    end
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = k;
        break;
      end
    end
    if (lat < 0) fail_now("response wait");
  endtask

  initial begin
    int           lat;
    int           n0;
    bit           seen;
    logic [511:0] wd;

    tbl[0]  = '{1'b0, 32'h1004, 32'h0, 4'h0, 32'hDEADBEEF, 7, 1, 0, 1};
    tbl[1]  = '{1'b0, 32'h1004, 32'h0, 4'h0, 32'hDEADBEEF, 1, 0, 1, 1};
    tbl[2]  = '{1'b1, 32'h1008, 32'h11223344, 4'b0011,
                32'hAABB3344, 1, 0, 2, 1};
    tbl[3]  = '{1'b0, 32'h1008, 32'h0, 4'h0, 32'hAABB3344, 1, 0, 3, 1};
    tbl[4]  = '{1'b0, 32'h5000, 32'h0, 4'h0, 32'h5A5A5000, 7, 1, 3, 2};
    tbl[5]  = '{1'b0, 32'h9000, 32'h0, 4'h0, 32'h5A5A9000, 8, 2, 3, 3};
    tbl[6]  = '{1'b0, 32'h1008, 32'h0, 4'h0, 32'hAABB3344, 7, 1, 3, 4};
    tbl[7]  = '{1'b1, 32'h9004, 32'hCAFEF00D, 4'b0000,
                32'h5A5A9004, 1, 0, 4, 4};
    tbl[8]  = '{1'b0, 32'h5040, 32'h0, 4'h0, 32'h5A5A5040, 7, 1, 4, 5};
    tbl[9]  = '{1'b1, 32'h5044, 32'hFFFFFFFF, 4'b1000,
                32'hFF5A5044, 1, 0, 5, 5};
    tbl[10] = '{1'b0, 32'hD000, 32'h0, 4'h0, 32'h5A5AD000, 7, 1, 5, 6};

    mem_store[32'h1004] = 32'hDEADBEEF;
    mem_store[32'h1008] = 32'hAABBCCDD;

    rst = 1'b0;
    req_valid = 1'b0;
    memRW = 1'b0;
    i_addr = '0;
    dataW = '0;
    wstrb = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset resp_valid", 32'(resp_valid), 32'd0);
    check("reset mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("reset o_data", o_data, 32'd0);
    check("reset hit_count", hit_count, 32'd0);
    check("reset miss_count", miss_count, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      n0 = mlog.size();
      do_req(tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].strb,
             tbl[i].exp_data, lat);
      @(posedge clk);
      #1;
      check($sformatf("v%0d latency", i), 32'(lat), 32'(tbl[i].exp_lat));
      check($sformatf("v%0d mem reqs", i), 32'(mlog.size() - n0),
            32'(tbl[i].exp_nreq));
      check($sformatf("v%0d hit_count", i), hit_count,
            32'(tbl[i].exp_hits));
      check($sformatf("v%0d miss_count", i), miss_count,
            32'(tbl[i].exp_miss));
      if (i == 0 && mlog.size() > n0) begin
        check("v0 refill we", 32'(mlog[n0].we), 32'd0);
        check("v0 refill addr", mlog[n0].addr, 32'h00001000);
      end
      if (i == 5 && mlog.size() > n0 + 1) begin
        wd = mlog[n0].wdata;
        check("v5 wb we", 32'(mlog[n0].we), 32'd1);
        check("v5 wb addr", mlog[n0].addr, 32'h00001000);
        check("v5 wb word2", wd[64 +: 32], 32'hAABB3344);
        check("v5 refill we", 32'(mlog[n0+1].we), 32'd0);
        check("v5 refill addr", mlog[n0+1].addr, 32'h00009000);
      end
    end

    // Refill request held off for five cycles, then a back-to-back hit.
    hold = 1'b1;
    exp_q.push_back(32'h5A5A2010);
    exp_q.push_back(32'h5A5A2010);
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    memRW = 1'b0;
    i_addr = 32'h2010;
    dataW = '0;
    wstrb = '0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_req_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_now("hold mem_req_valid");
    for (int c = 0; c < 5; c++) begin
      check($sformatf("hold c%0d valid", c), 32'(mem_req_valid), 32'd1);
      check($sformatf("hold c%0d addr", c), mem_req_addr, 32'h00002000);
      check($sformatf("hold c%0d we", c), 32'(mem_req_we), 32'd0);
      check($sformatf("hold c%0d stall", c), 32'(stall), 32'd1);
      check($sformatf("hold c%0d resp", c), 32'(resp_valid), 32'd0);
      if (c < 4) @(negedge clk);
    end
    hold = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_now("hold replay hit");
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    check("hold responses drained", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
    check("hold hit_count", hit_count, 32'd6);
    check("hold miss_count", miss_count, 32'd7);

    // Reset while waiting for a refill.
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    memRW = 1'b0;
    i_addr = 32'h3000;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready) begin
        seen = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (!seen) fail_now("rst-case accept");
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_req_valid && mem_req_ready && !mem_req_we) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) fail_now("rst-case refill request");
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async rst mem_req_valid", 32'(mem_req_valid), 32'd0);
    check("async rst hit_count", hit_count, 32'd0);
    check("async rst miss_count", miss_count, 32'd0);
    check("async rst req_ready", 32'(req_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    n0 = mlog.size();
    do_req(1'b0, 32'h1004, 32'h0, 4'h0, 32'hDEADBEEF, lat);
    @(posedge clk);
    #1;
    check("post-rst latency", 32'(lat), 32'd7);
    check("post-rst mem reqs", 32'(mlog.size() - n0), 32'd1);
    check("post-rst miss_count", miss_count, 32'd1);
    check("post-rst hit_count", hit_count, 32'd0);
    check("scoreboard empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dcache_sa_wb.md
Name: dcache_sa_wb

Overview:
- Parametrised N-way set-associative data cache for the rv32 pipeline, placed between the access stage and the line-wide backing memory.
- Write-back, write-allocate policy with round-robin replacement.
- Drives a stall to the pipeline while a miss is outstanding and keeps hit/miss statistics.
- Defaults produce an 18/8/6 tag/index/offset split of a 32-bit address.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, CPU word width
LINE_BYTES, 64, bytes per line (power of 2)
SETS, 256, number of sets (power of 2)
WAYS, 2, associativity (power of 2, >=1)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low
req_valid  in  1  CPU request present
req_ready  out  1  request accepted this cycle
memRW  in  1  1=store, 0=load
i_addr  in  ADDR_W  byte address; low log2(DATA_W/8) bits ignored
dataW  in  DATA_W  store data
wstrb  in  DATA_W/8  store byte enables
resp_valid  out  1  one-cycle response pulse
o_data  out  DATA_W  load data (store: merged word)
stall  out  1  req_valid & ~req_ready, combinational
mem_req_valid  out  1  memory request
mem_req_ready  in  1  memory accepts request
mem_req_we  out  1  1=line write-back, 0=line read
mem_req_addr  out  ADDR_W  line-aligned address
mem_wdata  out  LINE_BYTES*8  write-back line
mem_resp_valid  in  1  refill line present
mem_rdata  in  LINE_BYTES*8  refill line
hit_count  out  32  saturating hit counter
miss_count  out  32  saturating miss counter

Behaviour:
- Address split: offset = log2(LINE_BYTES), index = log2(SETS), tag = the remaining upper bits.
- Async reset:
  - State goes to IDLE.
  - All valid bits, dirty bits and per-set round-robin pointers clear.
  - Counters reset to 0.
  - mem_req_valid, resp_valid and o_data reset to 0; req_ready resets to 1.
  - Tag and data arrays are not reset.
- FSM states: IDLE, LOOKUP, WB_REQ, RF_REQ, RF_WAIT, FILL.
- IDLE:
  - req_ready=1.
  - On req_valid: register the request, read the arrays, go to LOOKUP.
- LOOKUP, hit:
  - resp_valid=1.
  - Load: o_data = the addressed word.
  - Store: merge by wstrb into the hit way and set dirty only if wstrb!=0; o_data = merged word.
  - hit_count++ unless this is a replay.
  - req_ready=1: a new request may be accepted in the same cycle (back-to-back hits give 1-cycle latency each).
- LOOKUP, miss:
  - miss_count++.
  - Victim = the set's round-robin pointer.
  - Victim valid and dirty: go to WB_REQ; otherwise go to RF_REQ.
- WB_REQ:
  - mem_req_valid=1, we=1, addr = {victim tag, index, 0}, wdata = victim line.
  - On mem_req_ready: go to RF_REQ. The write is posted; no response is expected.
- RF_REQ:
  - mem_req_valid=1, we=0, addr = line address of the request.
  - On ready: go to RF_WAIT.
- RF_WAIT:
  - On mem_resp_valid: capture mem_rdata, go to FILL.
- FILL:
  - Write line, tag, valid=1, dirty=0 into the victim way.
  - Advance the pointer (mod WAYS).
  - Go to LOOKUP as a replay. The replay hits and is not counted as a hit.
- req_ready=0 in every state except IDLE and a LOOKUP hit.
- While mem_req_valid=1 and mem_req_ready=0, addr/we/wdata hold stable.
- mem_resp_valid outside RF_WAIT is ignored.
- Miss latency is 4 cycles plus memory wait with no write-back; the write-back path adds 1 cycle plus its handshake wait.
- Counters saturate at 0xFFFFFFFF.
- Reset asserted mid-miss: abort immediately, mem_req_valid drops asynchronously, the line is lost, no partial fill.
- WAYS=1: degenerates to direct-mapped; the pointer is unused.

Decomposition:
- Package dcache_pkg holds:
  - the state enum;
  - derived-width constants/functions (OFF_W, IDX_W, TAG_W, WORDS_PER_LINE);
  - a word-merge function (wstrb).
- Sub-module dcache_way_array: one way's tag, data, valid and dirty storage with a synchronous read. It is instantiated WAYS times; hit detection, the FSM and counters stay in the top.

Test Plan:
1. After reset, load 0x00001004 -> miss; mem_req we=0 addr 0x00001000; return a line with word1=0xDEADBEEF -> resp_valid, o_data=0xDEADBEEF; miss_count=1, hit_count=0.
2. Load 0x00001004 again -> resp_valid the cycle after acceptance, no mem_req_valid, hit_count=1.
3. With word2 of the line = 0xAABBCCDD, store 0x00001008 dataW=0x11223344 wstrb=4'b0011 -> load 0x00001008 returns 0xAABB3344.
4. After test 3, load 0x00005000 and then 0x00009000 (all index 0x40).
   - The third line evicts way0 (0x1000, dirty): mem_req we=1 addr 0x00001000 with wdata word2=0xAABB3344.
   - This is followed by a read of 0x00009000; miss_count=3.
5. Hold mem_req_ready=0 for 5 cycles during RF_REQ -> mem_req_valid/addr/we stable, stall=1 throughout, no resp_valid.
6. Assert rst in RF_WAIT -> mem_req_valid=0 and counters=0 immediately; after release, load 0x00001004 misses again.
